// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants, types and helper functions for the AES-128 key schedule
// blocks (aes_inv_key_sched, aes_sbox).
//
// Contents:
//   RCON_FIRST / RCON_LAST  first and last forward round constants
//   RCON_INV_POLY           reduction term for the backward rcon step
//   XTIME_POLY              GF(2^8) reduction term for xtime
//   AES_ROUNDS              AES-128 round count
//   ks_state_t              key-schedule FSM state encoding
//   xtime / rcon_inv_step / rot_word helpers
//
// Configuration macro: AES_INV_KS_FWD_EN adds the ST_FWD state.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam logic [7:0]  RCON_FIRST    = 8'h01;
  localparam logic [7:0]  RCON_LAST     = 8'h36;
  localparam logic [7:0]  RCON_INV_POLY = 8'h8d;
  localparam logic [7:0]  XTIME_POLY    = 8'h1b;
  localparam int unsigned AES_ROUNDS    = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef AES_INV_KS_FWD_EN
    ST_FWD  = 2'd1,
`endif
    ST_EMIT = 2'd2
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ XTIME_POLY) : {b[6:0], 1'b0};
  endfunction

  // Divide by x in GF(2^8): undoes xtime, so it walks the forward rcon
  // sequence backwards (0x36 -> 0x1b -> 0x80 -> ... -> 0x01).
  function automatic logic [7:0] rcon_inv_step(input logic [7:0] r);
    return r[0] ? ((r >> 1) ^ RCON_INV_POLY) : (r >> 1);
  endfunction

  // Rotate a word left by one byte: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box. The multiplicative inverse is formed as
// x^254 by square-and-multiply in GF(2^8), followed by the affine transform.
//
// Ports:
//   in_byte   in  8  input byte
//   out_byte  out 8  SubBytes(in_byte)
// ---------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv_next;

  always_comb begin
    inv_next = gf_inv(in_byte);
    // Affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    out_byte = inv_next
             ^ {inv_next[6:0], inv_next[7]}
             ^ {inv_next[5:0], inv_next[7:6]}
             ^ {inv_next[4:0], inv_next[7:5]}
             ^ {inv_next[3:0], inv_next[7:4]}
             ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// ---------------------------------------------------------------------------
// aes_inv_key_sched
// Reverse AES-128 key schedule. Loads the round-10 key and emits round keys
// 10 down to 0 over a valid/ready handshake, one key per accepted transfer.
//
// Ports:
//   clk       in  1    clock
//   rstn      in  1    asynchronous active-low reset
//   kld       in  1    load pulse; samples key_in and restarts the sequence
//   key_in    in  128  round-10 key (cipher key with AES_INV_KS_FWD_EN)
//   rk_out    out 128  current round key, word 0 = [127:96]
//   rk_round  out 4    round index of rk_out
//   rk_valid  out 1    rk_out/rk_round valid
//   rk_ready  in  1    consumer accepts when rk_valid & rk_ready
//   busy      out 1    high from kld until round-0 key accepted
//   done      out 1    one-cycle pulse after round-0 key accepted
//
// Configuration macro: AES_INV_KS_FWD_EN -- key_in is the cipher key and a
// FWD state expands it to round 10 (10 cycles) before emitting. The four
// S-boxes are shared between forward and backward steps.
// ---------------------------------------------------------------------------
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         kld,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  ks_state_t    state_reg;
  logic [127:0] key_reg;
  logic [3:0]   round_reg;
  logic         valid_reg;
  logic         busy_reg;
  logic         done_reg;
  logic [7:0]   rcon_reg;
`ifdef AES_INV_KS_FWD_EN
  logic [3:0]   fwd_cnt_reg;
  logic [127:0] fwd_key_next;
`endif

  logic [31:0]  cur_w [4];
  logic [31:0]  bwd_w3_next;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  rcon_word;
  logic [127:0] prev_key_next;

  // Split the key register into words, word 0 in the top bits.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_words
      assign cur_w[gi] = key_reg[127-32*gi -: 32];
    end
  endgenerate

  assign rcon_word   = {rcon_reg, 24'h000000};
  assign bwd_w3_next = cur_w[3] ^ cur_w[2];

  // Backward step needs the previous key's w3, the forward step uses the
  // current w3; the shared S-box input is steered by state.
`ifdef AES_INV_KS_FWD_EN
  assign sub_in = (state_reg == ST_FWD) ? rot_word(cur_w[3]) : rot_word(bwd_w3_next);
`else
  assign sub_in = rot_word(bwd_w3_next);
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (sub_in[8*gi +: 8]),
        .out_byte (sub_out[8*gi +: 8])
      );
    end
  endgenerate

  assign prev_key_next = {cur_w[0] ^ sub_out ^ rcon_word,
                          cur_w[1] ^ cur_w[0],
                          cur_w[2] ^ cur_w[1],
                          bwd_w3_next};

`ifdef AES_INV_KS_FWD_EN
  logic [31:0] fwd_w0_next;
  logic [31:0] fwd_w1_next;
  logic [31:0] fwd_w2_next;
  logic [31:0] fwd_w3_next;

  assign fwd_w0_next  = cur_w[0] ^ sub_out ^ rcon_word;
  assign fwd_w1_next  = cur_w[1] ^ fwd_w0_next;
  assign fwd_w2_next  = cur_w[2] ^ fwd_w1_next;
  assign fwd_w3_next  = cur_w[3] ^ fwd_w2_next;
  assign fwd_key_next = {fwd_w0_next, fwd_w1_next, fwd_w2_next, fwd_w3_next};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      key_reg     <= '0;
      round_reg   <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rcon_reg    <= RCON_LAST;
`ifdef AES_INV_KS_FWD_EN
      fwd_cnt_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      // kld wins over everything, including a same-cycle handshake; the
      // aborted sequence produces no done pulse.
      if (kld) begin
        key_reg   <= key_in;
        round_reg <= 4'(AES_ROUNDS);
        busy_reg  <= 1'b1;
`ifdef AES_INV_KS_FWD_EN
        state_reg   <= ST_FWD;
        valid_reg   <= 1'b0;
        rcon_reg    <= RCON_FIRST;
        fwd_cnt_reg <= '0;
`else
        state_reg <= ST_EMIT;
        valid_reg <= 1'b1;
        rcon_reg  <= RCON_LAST;
`endif
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // Waiting for kld; rk_ready is ignored here.
          end
`ifdef AES_INV_KS_FWD_EN
          ST_FWD: begin
            key_reg <= fwd_key_next;
            if (fwd_cnt_reg == 4'(AES_ROUNDS - 1)) begin
              state_reg <= ST_EMIT;
              valid_reg <= 1'b1;
              round_reg <= 4'(AES_ROUNDS);
              rcon_reg  <= RCON_LAST;
            end else begin
              rcon_reg    <= xtime(rcon_reg);
              fwd_cnt_reg <= fwd_cnt_reg + 4'd1;
            end
          end
`endif
          ST_EMIT: begin
            if (rk_ready) begin
              if (round_reg == 4'd0) begin
                state_reg <= ST_IDLE;
                valid_reg <= 1'b0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                key_reg   <= prev_key_next;
                round_reg <= round_reg - 4'd1;
                rcon_reg  <= rcon_inv_step(rcon_reg);
              end
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rk_out   = key_reg;
  assign rk_round = round_reg;
  assign rk_valid = valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_sched
// Self-checking bench for aes_inv_key_sched. Expected round keys come from a
// textbook FIPS-197 word-array key expansion of a round-0 key; the S-box
// table is built by brute-force GF(2^8) inverse search plus the affine map.
// Works with or without AES_INV_KS_FWD_EN.
// ---------------------------------------------------------------------------
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rstn;
  logic         kld;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   sbox_tab [256];
  logic [7:0]   rc_tab   [11];
  logic [127:0] exp_rk   [11];

  aes_inv_key_sched dut (
    .clk      (clk),
    .rstn     (rstn),
    .kld      (kld),
    .key_in   (key_in),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int prod = 0;
    int aa   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ aa;
      aa = aa << 1;
      if (aa > 255) aa = aa ^ 'h11b;
    end
    return prod[7:0];
  endfunction

  task automatic build_tables;
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
    rc_tab[0] = 8'h00;
    rc_tab[1] = 8'h01;
    for (int i = 2; i < 11; i++) rc_tab[i] = gmul(rc_tab[i-1], 8'h02);
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key0);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc_tab[i/4], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Load a sequence given its round-0 key; returns at the first valid cycle.
  task automatic load_key(input logic [127:0] key0);
    expand(key0);
    kld = 1'b1;
`ifdef AES_INV_KS_FWD_EN
    key_in = key0;
`else
    key_in = exp_rk[10];
`endif
    tick;
    kld    = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_KS_FWD_EN
    for (int i = 0; i < 10; i++) begin
      check("fwd_busy", busy, 1);
      check("fwd_valid", rk_valid, 0);
      tick;
    end
`endif
  endtask

  // Walk the emit sequence from round start_r. Stops (without handshaking)
  // when stop_r is observed; stop_r < 0 runs through done.
  task automatic run_seq(input int start_r, input bit rand_ready, input int stop_r);
    int r   = start_r;
    int cyc = 0;
    bit fin = 1'b0;
    while (!fin && cyc < 300) begin
      check($sformatf("valid_r%0d", r), rk_valid, 1);
      check($sformatf("round_r%0d", r), rk_round, r);
      check($sformatf("key_r%0d", r), rk_out, exp_rk[r]);
      check($sformatf("busy_r%0d", r), busy, 1);
      check($sformatf("done_r%0d", r), done, 0);
      if (r >= 1) check($sformatf("rcon_r%0d", r), dut.rcon_reg, rc_tab[r]);
      if (r == stop_r) begin
        fin = 1'b1;
      end else begin
        rk_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        tick;
        cyc++;
        if (rk_ready) begin
          if (r == 0) begin
            check("done_pulse", done, 1);
            check("busy_end", busy, 0);
            check("valid_end", rk_valid, 0);
            tick;
            check("done_clear", done, 0);
            fin = 1'b1;
          end else begin
            r--;
          end
        end
      end
    end
    if (!fin) check("seq_timeout", 1, 0);
  endtask

  initial begin
    logic [127:0] k;
    build_tables;
    rstn     = 1'b0;
    kld      = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    tick;
    tick;
    check("rst_rk_out", rk_out, 0);
    check("rst_round", rk_round, 0);
    check("rst_valid", rk_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rcon", dut.rcon_reg, 8'h36);
    rstn = 1'b1;
    tick;

    // FIPS-197 vector, ready tied high.
    rk_ready = 1'b1;
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("fips_r10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_seq(10, 1'b0, 9);
    check("fips_r9", rk_out, 128'hac7766f319fadc2128d12941575c006e);
    run_seq(9, 1'b0, 0);
    check("fips_r0", rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_seq(0, 1'b0, -1);

    // Stall at round 7 for 5 cycles.
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    run_seq(10, 1'b0, 7);
    for (int i = 0; i < 5; i++) begin
      rk_ready = 1'b0;
      tick;
      check("stall_round", rk_round, 7);
      check("stall_key", rk_out, exp_rk[7]);
      check("stall_valid", rk_valid, 1);
    end
    rk_ready = 1'b1;
    tick;
    run_seq(6, 1'b0, -1);

    // kld together with a handshake at round 4.
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    run_seq(10, 1'b0, 4);
    rk_ready = 1'b1;
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    check("kld_no_done", done, 0);
    check("kld_round", rk_round, 10);
    check("kld_key", rk_out, exp_rk[10]);
    run_seq(10, 1'b1, -1);

    // Asynchronous reset mid-sequence.
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    run_seq(10, 1'b0, 6);
    rstn = 1'b0;
    #1;
    check("arst_rk_out", rk_out, 0);
    check("arst_round", rk_round, 0);
    check("arst_valid", rk_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    tick;
    rstn     = 1'b1;
    rk_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("idle_valid", rk_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end

    // Randomized keys with random backpressure.
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      run_seq(10, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
